// File: rtl/io_bus_fabric_pkg.sv
// Shared types and helpers for the CPU-to-I/O slave fabric: speed classes, lane modes,
// FSM states and the wait-state lookup.
package io_bus_fabric_pkg;

  typedef enum logic [1:0] {
    SpeedSlow = 2'd0,
    SpeedMed  = 2'd1,
    SpeedFast = 2'd2,
    SpeedSync = 2'd3
  } speed_e;

  typedef enum logic [1:0] {
    LaneByte    = 2'd0,
    LaneHalf    = 2'd1,
    LaneWord    = 2'd2,
    LaneWordAlt = 2'd3
  } lane_e;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StAccess,
    StDone,
    StUnmap
  } state_e;

  localparam logic [31:0] UnmappedData = 32'hFFFF_FFFF;
  localparam int unsigned WaitCntW     = 5;
  localparam int unsigned SlotIdxW     = 4;

  function automatic int unsigned ws_lookup(input logic [1:0]  speed,
                                            input int unsigned ws_slow,
                                            input int unsigned ws_med,
                                            input int unsigned ws_fast,
                                            input int unsigned ws_sync);
    case (speed_e'(speed))
      SpeedSlow: return ws_slow;
      SpeedMed:  return ws_med;
      SpeedFast: return ws_fast;
      default:   return ws_sync;
    endcase
  endfunction

endpackage

// File: rtl/io_bus_fabric_if.sv
// Wishbone-style bus bundle around the fabric. 'slave' is the fabric's own view (it serves the
// CPU request and drives the slot bus); 'master' is the surrounding CPU and slot environment.
interface io_bus_fabric_if #(
  parameter int unsigned NSLOTS = 8
);
  logic                   m_cyc;
  logic                   m_stb;
  logic                   m_we;
  logic [13:0]            m_adr;
  logic [31:0]            m_dat_i;
  logic [31:0]            m_dat_o;
  logic                   m_ack;
  logic                   m_err;
  logic [NSLOTS-1:0]      s_cyc;
  logic [NSLOTS-1:0]      s_stb;
  logic                   s_we;
  logic [13:0]            s_adr;
  logic [31:0]            s_dat_o;
  logic [NSLOTS*32-1:0]   s_dat_i;
  logic [NSLOTS-1:0]      s_ack;

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_i,
    input  m_dat_o, m_ack, m_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_o,
    output s_dat_i, s_ack
  );

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_i,
    output m_dat_o, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_o,
    input  s_dat_i, s_ack
  );

endinterface

// File: rtl/io_bus_fabric_lane_steer.sv
// Read-lane steering: narrow slots are zero-extended into the 32-bit CPU data bus.
module io_bus_fabric_lane_steer
  import io_bus_fabric_pkg::*;
(
  input  lane_e       mode,
  input  logic [31:0] raw,
  output logic [31:0] steered
);

  always_comb begin
    steered = raw;
    case (mode)
      LaneByte: steered = {24'h0, raw[7:0]};
      LaneHalf: steered = {16'h0, raw[15:0]};
      default:  steered = raw;
    endcase
  end

endmodule

// File: rtl/io_bus_fabric.sv
// CPU-to-I/O slave fabric: routes one master request to a decoded slot with per-speed wait
// states, lane steering, registered read data and a slave timeout.
module io_bus_fabric
  import io_bus_fabric_pkg::*;
#(
  parameter int unsigned         NSLOTS    = 8,
  parameter logic [2*NSLOTS-1:0] LANE_MODE = '0,
  parameter int unsigned         WS_SLOW   = 16,
  parameter int unsigned         WS_MED    = 8,
  parameter int unsigned         WS_FAST   = 4,
  parameter int unsigned         WS_SYNC   = 0,
  parameter int unsigned         TIMEOUT   = 64
) (
  input  logic                clkcpu,
  input  logic                rst_i,
  io_bus_fabric_if.slave      bus,
  input  logic [1:0]          speed_i,
  input  logic [NSLOTS-1:0]   slot_sel,
  output logic                busy,
  output logic [3:0]          err_slot
);

  localparam int unsigned    ToW    = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  state_e                state_q;
  logic [WaitCntW-1:0]   wait_cnt_q;
  logic [ToW-1:0]        to_cnt_q;
  logic [NSLOTS-1:0]     sel_oh_q;
  logic [SlotIdxW-1:0]   sel_idx_q;
  logic [NSLOTS-1:0]     s_cyc_q;
  logic [NSLOTS-1:0]     s_stb_q;
  logic                  we_q;
  logic [13:0]           adr_q;
  logic [31:0]           wdat_q;
  logic [31:0]           rdata_q;
  logic                  ack_q;
  logic                  err_q;
  logic [SlotIdxW-1:0]   err_slot_q;

  logic [NSLOTS-1:0]     req_oh;
  logic [SlotIdxW-1:0]   req_idx;
  int unsigned           req_ws;
  logic [31:0]           sel_data;
  lane_e                 sel_mode;
  logic [31:0]           steered;
  logic                  slot_ack;

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    req_oh  = '0;
    req_idx = '0;
    for (int k = int'(NSLOTS) - 1; k >= 0; k--) begin
      if (slot_sel[k]) begin
        req_oh    = '0;
        req_oh[k] = 1'b1;
        req_idx   = SlotIdxW'(k);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = LaneByte;
    for (int k = 0; k < int'(NSLOTS); k++) begin
      if (sel_oh_q[k]) begin
        sel_data = bus.s_dat_i[32*k +: 32];
        sel_mode = lane_e'(LANE_MODE[2*k +: 2]);
      end
    end
  end

  assign req_ws   = ws_lookup(speed_i, WS_SLOW, WS_MED, WS_FAST, WS_SYNC);
  assign slot_ack = |(bus.s_ack & sel_oh_q);

  io_bus_fabric_lane_steer u_lane_steer (
    .mode    (sel_mode),
    .raw     (sel_data),
    .steered (steered)
  );

  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      sel_oh_q   <= '0;
      sel_idx_q  <= '0;
      s_cyc_q    <= '0;
      s_stb_q    <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdata_q    <= UnmappedData;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_slot_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.m_cyc && bus.m_stb) begin
            if (req_oh == '0) begin
              state_q <= StUnmap;
              ack_q   <= 1'b1;
              rdata_q <= UnmappedData;
            end else begin
              sel_oh_q  <= req_oh;
              sel_idx_q <= req_idx;
              we_q      <= bus.m_we;
              adr_q     <= bus.m_adr;
              wdat_q    <= bus.m_dat_i;
              to_cnt_q  <= '0;
              s_cyc_q   <= req_oh;
              if (req_ws == 0) begin
                state_q <= StAccess;
                s_stb_q <= req_oh;
              end else begin
                state_q    <= StWait;
                wait_cnt_q <= WaitCntW'(req_ws - 1);
              end
            end
          end
        end
        StWait: begin
          if (!bus.m_cyc) begin
            state_q <= StIdle;
            s_cyc_q <= '0;
            s_stb_q <= '0;
          end else if (wait_cnt_q == '0) begin
            state_q <= StAccess;
            s_stb_q <= sel_oh_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        StAccess: begin
          if (!bus.m_cyc) begin
            state_q <= StIdle;
            s_cyc_q <= '0;
            s_stb_q <= '0;
          end else if (slot_ack) begin
            // Ack is tested first so an ack in the final timeout cycle still completes cleanly.
            state_q <= StDone;
            ack_q   <= 1'b1;
            s_cyc_q <= '0;
            s_stb_q <= '0;
            if (!we_q) rdata_q <= steered;
          end else if (to_cnt_q == ToLast) begin
            state_q    <= StDone;
            err_q      <= 1'b1;
            s_cyc_q    <= '0;
            s_stb_q    <= '0;
            rdata_q    <= UnmappedData;
            err_slot_q <= sel_idx_q;
          end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StUnmap: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_dat_o = rdata_q;
  assign bus.m_ack   = ack_q;
  assign bus.m_err   = err_q;
  assign bus.s_cyc   = s_cyc_q;
  assign bus.s_stb   = s_stb_q;
  assign bus.s_we    = we_q;
  assign bus.s_adr   = adr_q;
  assign bus.s_dat_o = wdat_q;
  assign busy        = (state_q != StIdle);
  assign err_slot    = err_slot_q;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Bench for io_bus_fabric: directed corner cases plus random transactions against a
// transaction-level model of latency, data steering and timeout.
module tb_io_bus_fabric;

  localparam int unsigned NSlots   = 8;
  localparam logic [15:0] LaneMode = 16'h8984;
  localparam int          Timeout  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] speed;
  logic [7:0] slot_sel;
  logic       busy;
  logic [3:0] err_slot;

  io_bus_fabric_if #(.NSLOTS(NSlots)) bus ();

  io_bus_fabric #(
    .NSLOTS    (NSlots),
    .LANE_MODE (LaneMode),
    .WS_SLOW   (16),
    .WS_MED    (8),
    .WS_FAST   (4),
    .WS_SYNC   (0),
    .TIMEOUT   (Timeout)
  ) dut (
    .clkcpu   (clk),
    .rst_i    (rst),
    .bus      (bus),
    .speed_i  (speed),
    .slot_sel (slot_sel),
    .busy     (busy),
    .err_slot (err_slot)
  );

  always #5 clk = ~clk;

  // Model tables: wait states per speed code, lane width per slot (0 byte, 1 half, 2 word).
  int ws_tab[4]   = '{16, 8, 4, 0};
  int lane_tab[8] = '{0, 1, 0, 2, 1, 2, 0, 2};

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rd = 32'hFFFF_FFFF;
  logic [3:0]  model_err_slot = 4'd0;

  // Slave model: the selected slot acks after ack_delay strobed cycles; noise slots always ack.
  logic [7:0] ack_oh = 8'h00;
  logic [7:0] noise = 8'h00;
  int         ack_delay = 0;
  int         stb_cnt = 0;

  always @(negedge clk) begin
    if (|(bus.s_stb & ack_oh)) begin
      bus.s_ack <= ((stb_cnt >= ack_delay) ? ack_oh : 8'h00) | noise;
      stb_cnt   <= stb_cnt + 1;
    end else begin
      bus.s_ack <= noise;
      stb_cnt   <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] lane_mask(input int k);
    case (lane_tab[k])
      0:       return 32'h0000_00FF;
      1:       return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic run_req(input logic [7:0] sel, input logic [1:0] spd, input logic we,
                         input int delay, input logic [7:0] nz,
                         input bit fix_dat, input logic [31:0] fixed);
    int          k, ws, n, waits, first_stb, exp_n;
    bit          done, got_ack, got_err, bad, exp_ack;
    logic [7:0]  exp_oh;
    logic [13:0] adr_v, seen_adr;
    logic [31:0] wdat_v, seen_wdat, exp_dat;
    logic        seen_we;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) bus.s_dat_i[32*i +: 32] = $urandom;
    k = lowest(sel);
    if (fix_dat && k >= 0) bus.s_dat_i[32*k +: 32] = fixed;
    adr_v  = 14'($urandom);
    wdat_v = $urandom;
    exp_oh = (k >= 0) ? (8'h01 << k) : 8'h00;
    ack_oh    = exp_oh;
    ack_delay = delay;
    noise     = nz & ~exp_oh;
    bus.m_cyc = 1'b1; bus.m_stb = 1'b1; bus.m_we = we;
    bus.m_adr = adr_v; bus.m_dat_i = wdat_v;
    speed = spd; slot_sel = sel;
    ws = ws_tab[spd];
    if (k < 0) begin
      exp_n = 1; exp_ack = 1'b1; model_rd = 32'hFFFF_FFFF;
    end else if (delay < Timeout) begin
      exp_n = ws + 2 + delay; exp_ack = 1'b1;
      if (!we) model_rd = bus.s_dat_i[32*k +: 32] & lane_mask(k);
    end else begin
      exp_n = ws + 1 + Timeout; exp_ack = 1'b0;
      model_rd = 32'hFFFF_FFFF; model_err_slot = 4'(k);
    end
    exp_dat = model_rd;
    n = 0; waits = 0; first_stb = 0; done = 0; bad = 0; got_ack = 0; got_err = 0;
    seen_adr = '0; seen_wdat = '0; seen_we = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == 1) slot_sel = 8'($urandom);
      if (bus.s_cyc != 8'h00 && bus.s_cyc != exp_oh) bad = 1;
      if ((bus.s_stb & ~bus.s_cyc) != 8'h00) bad = 1;
      if (bus.m_ack && bus.m_err) bad = 1;
      if (bus.s_cyc != 8'h00 && bus.s_stb == 8'h00) waits++;
      if (bus.s_stb != 8'h00 && first_stb == 0) begin
        first_stb = n; seen_adr = bus.s_adr; seen_wdat = bus.s_dat_o; seen_we = bus.s_we;
      end
      if (bus.m_ack || bus.m_err) begin
        done = 1; got_ack = bus.m_ack; got_err = bus.m_err;
      end
    end
    bus.m_cyc = 1'b0; bus.m_stb = 1'b0;
    check("latency", 32'(n), 32'(exp_n));
    check("ack", {31'h0, got_ack}, {31'h0, exp_ack});
    check("err", {31'h0, got_err}, {31'h0, ~exp_ack});
    check("rdata", bus.m_dat_o, exp_dat);
    check("err_slot", {28'h0, err_slot}, {28'h0, model_err_slot});
    check("slot_onehot", {31'h0, bad}, 32'h0);
    check("wait_cycles", 32'(waits), (k >= 0) ? 32'(ws) : 32'h0);
    check("first_stb", 32'(first_stb), (k >= 0) ? 32'(ws + 1) : 32'h0);
    if (k >= 0) begin
      check("s_adr", {18'h0, seen_adr}, {18'h0, adr_v});
      check("s_dat_o", seen_wdat, wdat_v);
      check("s_we", {31'h0, seen_we}, {31'h0, we});
    end
    @(posedge clk); #1;
    check("strobe_one_cycle", {30'h0, bus.m_ack, bus.m_err}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    bus.m_cyc = 1'b0; bus.m_stb = 1'b0; bus.m_we = 1'b0;
    bus.m_adr = '0; bus.m_dat_i = '0; bus.s_dat_i = '0;
    speed = 2'd0; slot_sel = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ack", {31'h0, bus.m_ack}, 32'h0);
    check("rst_m_err", {31'h0, bus.m_err}, 32'h0);
    check("rst_s_cyc", {24'h0, bus.s_cyc}, 32'h0);
    check("rst_s_stb", {24'h0, bus.s_stb}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_m_dat_o", bus.m_dat_o, 32'hFFFF_FFFF);
    check("rst_err_slot", {28'h0, err_slot}, 32'h0);
    rst = 1'b0;

    // Slot 2 byte lane, sync speed, immediate ack.
    run_req(8'h04, 2'd3, 1'b0, 0, 8'h00, 1'b1, 32'h1234_56AB);
    check("t1_byte_data", bus.m_dat_o, 32'h0000_00AB);
    // Slow speed on a word slot.
    run_req(8'h08, 2'd0, 1'b0, 0, 8'h00, 1'b0, 32'h0);
    // Unmapped access.
    run_req(8'h00, 2'd1, 1'b0, 0, 8'h00, 1'b0, 32'h0);
    // Slot 5 never acks; other slots' acks must be ignored.
    run_req(8'h20, 2'd3, 1'b0, 1000, 8'hDF, 1'b0, 32'h0);
    check("t4_err_slot", {28'h0, err_slot}, 32'd5);
    // Ack in the final timeout cycle beats the timeout.
    run_req(8'h02, 2'd2, 1'b0, Timeout - 1, 8'h00, 1'b0, 32'h0);
    run_req(8'h80, 2'd3, 1'b0, Timeout, 8'h00, 1'b0, 32'h0);
    // Write leaves read data untouched; two slots selected, lowest wins.
    run_req(8'h24, 2'd2, 1'b1, 2, 8'h00, 1'b0, 32'h0);

    // Abort in WAIT by dropping m_cyc.
    @(posedge clk); #1;
    ack_oh = 8'h00; noise = 8'h00;
    bus.m_cyc = 1'b1; bus.m_stb = 1'b1; bus.m_we = 1'b0;
    speed = 2'd0; slot_sel = 8'h24;
    repeat (5) @(posedge clk);
    #1;
    check("abort_wait_cyc", {24'h0, bus.s_cyc}, 32'h04);
    check("abort_wait_stb", {24'h0, bus.s_stb}, 32'h0);
    bus.m_cyc = 1'b0; bus.m_stb = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_s_cyc", {24'h0, bus.s_cyc}, 32'h0);
    check("abort_no_strobe", {30'h0, bus.m_ack, bus.m_err}, 32'h0);
    @(posedge clk); #1;
    check("abort_no_late_ack", {30'h0, bus.m_ack, bus.m_err}, 32'h0);

    // Reset pulsed while a slot is being accessed.
    bus.m_cyc = 1'b1; bus.m_stb = 1'b1; speed = 2'd3; slot_sel = 8'h01;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_stb", {24'h0, bus.s_stb}, 32'h01);
    rst = 1'b1; bus.m_cyc = 1'b0; bus.m_stb = 1'b0;
    @(posedge clk); #1;
    check("rst_op_s_cyc", {24'h0, bus.s_cyc}, 32'h0);
    check("rst_op_s_stb", {24'h0, bus.s_stb}, 32'h0);
    check("rst_op_strobes", {30'h0, bus.m_ack, bus.m_err}, 32'h0);
    check("rst_op_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    model_rd = 32'hFFFF_FFFF; model_err_slot = 4'd0;
    run_req(8'h01, 2'd3, 1'b0, 2, 8'h00, 1'b0, 32'h0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] sel;
      int         dly;
      sel = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      dly = ($urandom_range(0, 9) == 0) ? Timeout : $urandom_range(0, 6);
      run_req(sel, 2'($urandom), 1'($urandom), dly, 8'($urandom), 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
